// File: rtl/subtraction_3200_128_pkg.sv
// Shared constants and types for the 3200-bit borrow-select subtractor.
// Operands are NBLK slices of BLOCK bits; each slice result carries its borrow in bit BLOCK.
package subtraction_3200_128_pkg;

    localparam int BLOCK = 128;
    localparam int NBLK  = 25;
    localparam int SIZE  = BLOCK * NBLK;

    typedef enum logic [1:0] {
        IDLE,
        CALC0,
        CALC1,
        SEL
    } state_t;

    // {borrow, diff} for one block slice
    typedef logic [BLOCK:0] block_t;

endpackage

// File: rtl/subtraction_3200_128_unit_subtractor.sv
// One block slice of the borrow-select subtractor: {borrow, diff} = a - b - bin.
// A negative result wraps modulo 2^(BLOCK+1), so the top bit is set exactly when a block borrows.
module unit_subtractor
    import subtraction_3200_128_pkg::*;
(
    input  logic [BLOCK-1:0] a,
    input  logic [BLOCK-1:0] b,
    input  logic             bin,
    output block_t           y
);

    assign y = {1'b0, a} - {1'b0, b} - {{BLOCK{1'b0}}, bin};

endmodule

// File: rtl/subtraction_3200_128.sv
// Multi-cycle 3200-bit subtractor: d = a - b, borrow_out = (a < b), r = borrow_out ? a : d.
// Both borrow-in variants of every block are computed on shared unit subtractors, then the chain is resolved.
module subtraction_3200_128
    import subtraction_3200_128_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    output logic [SIZE-1:0] d,
    output logic [SIZE-1:0] r,
    output logic            borrow_out,
    output logic            busy,
    output logic            en_out
);

    state_t          state;
    logic [SIZE-1:0] a_reg;
    logic [SIZE-1:0] b_reg;
    block_t          p0       [NBLK];
    block_t          p1       [NBLK];
    block_t          unit_out [NBLK];
    logic            bin;
    logic [SIZE-1:0] d_next;
    logic            borrow_next;
    block_t          sel;

    // The same subtractors serve both passes; only the borrow-in changes.
    assign bin  = (state == CALC1);
    assign busy = (state != IDLE);

    for (genvar gi = 0; gi < NBLK; gi++) begin : g_unit
        unit_subtractor u_sub (
            .a   (a_reg[gi*BLOCK +: BLOCK]),
            .b   (b_reg[gi*BLOCK +: BLOCK]),
            .bin (bin),
            .y   (unit_out[gi])
        );
    end

    // Walk the borrow chain from block 0 upward, picking the precomputed variant.
    always_comb begin
        borrow_next = 1'b0;
        d_next      = '0;
        sel         = '0;
        for (int i = 0; i < NBLK; i++) begin
            sel = borrow_next ? p1[i] : p0[i];
            d_next[i*BLOCK +: BLOCK] = sel[BLOCK-1:0];
            borrow_next = sel[BLOCK];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            a_reg      <= '0;
            b_reg      <= '0;
            d          <= '0;
            r          <= '0;
            borrow_out <= 1'b0;
            en_out     <= 1'b0;
            for (int i = 0; i < NBLK; i++) begin
                p0[i] <= '0;
                p1[i] <= '0;
            end
        end else begin
            en_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (en) begin
                        a_reg <= a;
                        b_reg <= b;
                        state <= CALC0;
                    end
                end
                CALC0: begin
                    for (int i = 0; i < NBLK; i++) begin
                        p0[i] <= unit_out[i];
                    end
                    state <= CALC1;
                end
                CALC1: begin
                    for (int i = 0; i < NBLK; i++) begin
                        p1[i] <= unit_out[i];
                    end
                    state <= SEL;
                end
                SEL: begin
                    d          <= d_next;
                    borrow_out <= borrow_next;
                    r          <= borrow_next ? a_reg : d_next;
                    en_out     <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_subtraction_3200_128.sv
// Directed self-checking bench for subtraction_3200_128 with hand-computed expected results.
module tb_subtraction_3200_128;

    localparam int SIZE = 3200;

    logic            clk;
    logic            rst_n;
    logic            en;
    logic [SIZE-1:0] a;
    logic [SIZE-1:0] b;
    logic [SIZE-1:0] d;
    logic [SIZE-1:0] r;
    logic            borrow_out;
    logic            busy;
    logic            en_out;

    int compared;
    int mismatched;

    subtraction_3200_128 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .a          (a),
        .b          (b),
        .d          (d),
        .r          (r),
        .borrow_out (borrow_out),
        .busy       (busy),
        .en_out     (en_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Presents operands with en for one edge; returns 1 ns after the accepting edge.
    task automatic start_op(input logic [SIZE-1:0] av, input logic [SIZE-1:0] bv);
        a  = av;
        b  = bv;
        en = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b0;
        a  = '0;
        b  = '0;
    endtask

    // Counts edges until en_out is seen (99 on timeout) and busy cycles before it.
    task automatic wait_result(output int lat, output int busy_cnt);
        lat      = 99;
        busy_cnt = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (en_out) begin
                lat = i;
                return;
            end
            if (busy) busy_cnt++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en    = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(posedge clk);
        #1;
        compared++;
        if ({d, r, borrow_out, en_out, busy} !== '0) begin
            mismatched++;
            $display("[TB] FAIL reset_outputs: got d=%0h r=%0h borrow=%0b en_out=%0b busy=%0b, need all 0",
                     d, r, borrow_out, en_out, busy);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int lat, bc;
        start_op(5, 3);
        compared++;
        if (busy !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL basic_busy_start: got %0b need 1", busy);
        end
        wait_result(lat, bc);
        compared++;
        if (lat !== 3) begin
            mismatched++;
            $display("[TB] FAIL basic_latency: got %0d need 3", lat);
        end
        compared++;
        if (bc !== 2) begin
            mismatched++;
            $display("[TB] FAIL basic_busy_cycles: got %0d need 2 after accept", bc);
        end
        compared++;
        if (d !== 3200'd2 || borrow_out !== 1'b0 || r !== 3200'd2 || busy !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL basic_result: got d=%0h borrow=%0b r=%0h busy=%0b need d=2 borrow=0 r=2 busy=0",
                     d, borrow_out, r, busy);
        end
        @(posedge clk);
        #1;
        compared++;
        if (en_out !== 1'b0 || d !== 3200'd2) begin
            mismatched++;
            $display("[TB] FAIL basic_pulse_hold: got en_out=%0b d=%0h need en_out=0 d=2", en_out, d);
        end
    endtask

    task automatic test_negative();
        int lat, bc;
        logic [SIZE-1:0] exp_d;
        exp_d = {{(SIZE-1){1'b1}}, 1'b0};
        start_op(3, 5);
        wait_result(lat, bc);
        compared++;
        if (lat !== 3 || d !== exp_d || borrow_out !== 1'b1 || r !== 3200'd3) begin
            mismatched++;
            $display("[TB] FAIL negative: got lat=%0d borrow=%0b r=%0h d_low=%0h need lat=3 borrow=1 r=3 d=2^3200-2",
                     lat, borrow_out, r, d[31:0]);
        end
    endtask

    task automatic test_ripple();
        int lat, bc;
        logic [SIZE-1:0] av, exp_d;
        av    = {1'b1, {(SIZE-1){1'b0}}};
        exp_d = {1'b0, {(SIZE-1){1'b1}}};
        start_op(av, 1);
        wait_result(lat, bc);
        compared++;
        if (lat !== 3 || d !== exp_d || borrow_out !== 1'b0 || r !== exp_d) begin
            mismatched++;
            $display("[TB] FAIL ripple: got lat=%0d borrow=%0b d_top=%0h d_low=%0h need lat=3 borrow=0 d=2^3199-1",
                     lat, borrow_out, d[SIZE-1 -: 32], d[31:0]);
        end
    endtask

    task automatic test_equal_ignore();
        int lat, bc, pulses;
        logic [SIZE-1:0] pat;
        pat = {100{32'hDEADBEEF}};
        start_op(pat, pat);
        // Now in CALC0; this en lands on the CALC1 edge and must be dropped.
        @(posedge clk);
        #1;
        a  = 3200'd100;
        b  = 3200'd1;
        en = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b0;
        a  = '0;
        b  = '0;
        wait_result(lat, bc);
        compared++;
        if (lat !== 1 || d !== '0 || borrow_out !== 1'b0 || r !== '0) begin
            mismatched++;
            $display("[TB] FAIL equal_operands: got lat=%0d borrow=%0b d_low=%0h r_low=%0h need lat=1 (edge k+3) d=0 r=0 borrow=0",
                     lat, borrow_out, d[31:0], r[31:0]);
        end
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (en_out || busy) pulses++;
        end
        compared++;
        if (pulses !== 0 || d !== '0) begin
            mismatched++;
            $display("[TB] FAIL ignored_en: got extra_activity=%0d d_low=%0h need 0 and d=0", pulses, d[31:0]);
        end
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        logic [SIZE-1:0] exp_d;
        exp_d = '0;
        exp_d = exp_d - 3200'd5;
        start_op(7, 2);
        wait_result(lat, bc);
        compared++;
        if (lat !== 3 || d !== 3200'd5 || borrow_out !== 1'b0 || r !== 3200'd5) begin
            mismatched++;
            $display("[TB] FAIL b2b_first: got lat=%0d d=%0h borrow=%0b r=%0h need lat=3 d=5 borrow=0 r=5",
                     lat, d[31:0], borrow_out, r[31:0]);
        end
        start_op(2, 7);
        compared++;
        if (en_out !== 1'b0 || busy !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL b2b_accept: got en_out=%0b busy=%0b need en_out=0 busy=1", en_out, busy);
        end
        wait_result(lat, bc);
        compared++;
        if (lat !== 3 || d !== exp_d || borrow_out !== 1'b1 || r !== 3200'd2) begin
            mismatched++;
            $display("[TB] FAIL b2b_second: got lat=%0d d_low=%0h borrow=%0b r=%0h need lat=3 d=2^3200-5 borrow=1 r=2",
                     lat, d[31:0], borrow_out, r[31:0]);
        end
    endtask

    task automatic test_reset_midop();
        int lat, bc, pulses;
        start_op(9, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        compared++;
        if ({d, r, borrow_out, en_out, busy} !== '0) begin
            mismatched++;
            $display("[TB] FAIL midop_reset: got d=%0h r=%0h borrow=%0b en_out=%0b busy=%0b need all 0",
                     d[31:0], r[31:0], borrow_out, en_out, busy);
        end
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (en_out) pulses++;
        end
        compared++;
        if (pulses !== 0) begin
            mismatched++;
            $display("[TB] FAIL midop_no_pulse: got %0d en_out pulses need 0", pulses);
        end
        start_op(10, 4);
        wait_result(lat, bc);
        compared++;
        if (lat !== 3 || d !== 3200'd6 || borrow_out !== 1'b0 || r !== 3200'd6) begin
            mismatched++;
            $display("[TB] FAIL after_reset_op: got lat=%0d d=%0h borrow=%0b r=%0h need lat=3 d=6 borrow=0 r=6",
                     lat, d[31:0], borrow_out, r[31:0]);
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        test_reset();
        test_basic();
        test_negative();
        test_ripple();
        test_equal_ignore();
        test_back_to_back();
        test_reset_midop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
